// File: rtl/lc3_ifetch.sv
// lc3_ifetch: LC-3 instruction-fetch front end with a req/ack memory port, timeout fault and flush.
// Define LC3_IFETCH_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module lc3_ifetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       MAX_WAIT = 15,
    parameter logic [DATA_W-1:0] FAULT_IR = 16'hF025
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              flush,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // PF* states exist only when the prefetch buffer is built in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_PF,
        S_PFHIT,
        S_PFDRAIN
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [7:0]        cnt_q, cnt_d;

    logic accept;
    logic ack;
    logic tmo;

    assign accept = fetch_req && !busy_q;
    assign ack    = mem_ack && mem_rd_q;
    assign tmo    = !ack && (cnt_q == CNT_LAST);

`ifdef LC3_IFETCH_PREFETCH_EN
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              hit_idle;
    logic              hit_fly;

    // A flush-qualified request never hits: buffered data belongs to the old stream.
    assign hit_fly  = !flush && (fetch_pc == pf_addr_q);
    assign hit_idle = hit_fly && pf_valid_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            cnt_q      <= '0;
`ifdef LC3_IFETCH_PREFETCH_EN
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            cnt_q      <= cnt_d;
`ifdef LC3_IFETCH_PREFETCH_EN
            pf_addr_q  <= pf_addr_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
            pend_q     <= pend_d;
`endif
        end
    end

    // An ack on the timeout edge wins; a flush on the timeout edge aborts silently.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef LC3_IFETCH_PREFETCH_EN
                    state_d = hit_idle ? S_PF : S_WAIT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                if (ack) begin
`ifdef LC3_IFETCH_PREFETCH_EN
                    state_d = flush ? S_IDLE : S_PF;
`else
                    state_d = S_IDLE;
`endif
                end else if (tmo) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ack || tmo) begin
                    state_d = S_IDLE;
                end
            end
`ifdef LC3_IFETCH_PREFETCH_EN
            S_PF: begin
                if (accept) begin
                    if (hit_fly && ack) begin
                        state_d = S_PF;
                    end else if (ack || tmo) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = hit_fly ? S_PFHIT : S_PFDRAIN;
                    end
                end else if (ack || tmo) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_PFHIT: begin
                if (ack) begin
                    state_d = flush ? S_IDLE : S_PF;
                end else if (tmo) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_PFDRAIN: begin
                if (ack || tmo) begin
                    state_d = flush ? S_IDLE : S_WAIT;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        fault_d    = fault_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = (state_d == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
        busy_d     = (state_d == S_WAIT) || (state_d == S_DRAIN) ||
                     (state_d == S_PFHIT) || (state_d == S_PFDRAIN);
        mem_rd_d   = (state_d != S_IDLE);
`ifdef LC3_IFETCH_PREFETCH_EN
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q && !flush;
        pend_d     = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fault_d    = 1'b0;
                    cnt_d      = 8'd0;
                    mem_addr_d = fetch_pc;
`ifdef LC3_IFETCH_PREFETCH_EN
                    if (hit_idle) begin
                        ir_d       = pf_data_q;
                        ir_valid_d = 1'b1;
                        mem_addr_d = pf_addr_q + ONE;
                        pf_addr_d  = pf_addr_q + ONE;
                        pf_valid_d = 1'b0;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (ack) begin
                    if (!flush) begin
                        ir_d       = mem_rdata;
                        ir_valid_d = 1'b1;
`ifdef LC3_IFETCH_PREFETCH_EN
                        mem_addr_d = mem_addr_q + ONE;
                        pf_addr_d  = mem_addr_q + ONE;
                        pf_valid_d = 1'b0;
                        cnt_d      = 8'd0;
`endif
                    end
                end else if (tmo && !flush) begin
                    ir_d       = FAULT_IR;
                    ir_valid_d = 1'b1;
                    fault_d    = 1'b1;
`ifdef LC3_IFETCH_PREFETCH_EN
                    pf_valid_d = 1'b0;
`endif
                end
            end
`ifdef LC3_IFETCH_PREFETCH_EN
            S_PF: begin
                if (accept) begin
                    fault_d = 1'b0;
                    if (hit_fly && ack) begin
                        ir_d       = mem_rdata;
                        ir_valid_d = 1'b1;
                        mem_addr_d = pf_addr_q + ONE;
                        pf_addr_d  = pf_addr_q + ONE;
                        cnt_d      = 8'd0;
                    end else if (ack || tmo) begin
                        mem_addr_d = fetch_pc;
                        cnt_d      = 8'd0;
                    end else if (!hit_fly) begin
                        pend_d = fetch_pc;
                    end
                end else if (ack && !flush) begin
                    pf_data_d  = mem_rdata;
                    pf_valid_d = 1'b1;
                end
            end
            S_PFHIT: begin
                if (ack && !flush) begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    mem_addr_d = pf_addr_q + ONE;
                    pf_addr_d  = pf_addr_q + ONE;
                    cnt_d      = 8'd0;
                end
            end
            S_PFDRAIN: begin
                if ((ack || tmo) && !flush) begin
                    mem_addr_d = pend_q;
                    cnt_d      = 8'd0;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign busy        = busy_q;
    assign fetch_fault = fault_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_lc3_ifetch.sv
// tb_lc3_ifetch: scoreboard bench for lc3_ifetch; stimulus queues expected ir/fault/cycle,
// a monitor checks every ir_valid pulse against the queue head.
module tb_lc3_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchReq;
    logic [15:0] fetchPc;
    logic        flush;
    logic [15:0] ir;
    logic        irValid;
    logic        busy;
    logic        fetchFault;
    logic [15:0] memAddr;
    logic        memRd;
    logic [15:0] memRdata = 16'h0000;
    logic        memAck = 1'b0;

    typedef struct {
        logic [15:0] ir;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          memLat = 0;
    int          waitCnt = 0;
    logic [15:0] memData = 16'h0000;
    logic        useMap = 1'b0;
    logic        lateAck = 1'b0;

    lc3_ifetch dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetchReq),
        .fetch_pc   (fetchPc),
        .flush      (flush),
        .ir         (ir),
        .ir_valid   (irValid),
        .busy       (busy),
        .fetch_fault(fetchFault),
        .mem_addr   (memAddr),
        .mem_rd     (memRd),
        .mem_rdata  (memRdata),
        .mem_ack    (memAck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // Memory answers memLat cycles after mem_rd rises (memLat < 0: never); lateAck pulses an ack while idle.
    always @(posedge clk) begin
        #2;
        if (reset || !memRd) begin
            memAck   = lateAck && !reset;
            memRdata = 16'hDEAD;
            waitCnt  = 0;
        end else if (memAck) begin
            memAck  = 1'b0;
            waitCnt = 0;
        end else if (memLat >= 0 && waitCnt == memLat) begin
            memAck   = 1'b1;
            memRdata = useMap ? memWord(memAddr) : memData;
        end else begin
            waitCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one fetch request for a cycle; latency counts cycles from the accepting edge to ir_valid.
    task automatic applyStimulus(input logic [15:0] pc, input bit doPush, input logic [15:0] expIr,
                                 input logic expFault, input int latency);
        exp_t e;
        fetchReq = 1'b1;
        fetchPc  = pc;
        if (doPush) begin
            e.ir    = expIr;
            e.fault = expFault;
            e.cyc   = cyc + 1 + latency;
            expQ.push_back(e);
        end
        @(negedge clk);
        fetchReq = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitIdle(input int maxCyc);
        int k = 0;
        while ((busy || memRd) && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        checkOutput("idleReached", 32'({busy, memRd}), 32'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && irValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedIrValid", 32'(irValid), 32'h0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("irValue", 32'(ir), 32'(monExp.ir));
                checkOutput("irFault", 32'(fetchFault), 32'(monExp.fault));
                checkOutput("irCycle", 32'(cyc), 32'(monExp.cyc));
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        fetchReq = 1'b0;
        fetchPc  = 16'h0000;
        flush    = 1'b0;
        waitCycles(2);
        checkOutput("rstIr", 32'(ir), 32'h0);
        checkOutput("rstIrValid", 32'(irValid), 32'h0);
        checkOutput("rstBusy", 32'(busy), 32'h0);
        checkOutput("rstFault", 32'(fetchFault), 32'h0);
        checkOutput("rstMemRd", 32'(memRd), 32'h0);
        checkOutput("rstMemAddr", 32'(memAddr), 32'h0);
        reset = 1'b0;
        waitCycles(1);

`ifdef LC3_IFETCH_PREFETCH_EN
        useMap = 1'b1;
        memLat = 0;
        applyStimulus(16'h3000, 1'b1, 16'h00FF, 1'b0, 1);
        waitIdle(20);
        applyStimulus(16'h3001, 1'b1, 16'h01FE, 1'b0, 0);
        checkOutput("pfNextAddr", 32'(memAddr), 32'h3002);
        checkOutput("pfHitBusy", 32'(busy), 32'h0);
        waitIdle(20);
        applyStimulus(16'hFFFF, 1'b1, 16'hFF00, 1'b0, 1);
        waitCycles(1);
        checkOutput("pfWrapAddr", 32'(memAddr), 32'h0000);
        checkOutput("pfWrapRd", 32'(memRd), 32'h1);
        waitIdle(20);
`else
        // Two-wait memory; a request while busy must be dropped.
        memLat  = 2;
        memData = 16'h1263;
        applyStimulus(16'h3000, 1'b1, 16'h1263, 1'b0, 3);
        checkOutput("t1MemAddr", 32'(memAddr), 32'h3000);
        checkOutput("t1MemRd", 32'(memRd), 32'h1);
        checkOutput("t1Busy", 32'(busy), 32'h1);
        applyStimulus(16'h5555, 1'b0, 16'h0000, 1'b0, 0);
        checkOutput("t1AddrHeld", 32'(memAddr), 32'h3000);
        waitIdle(20);
        checkOutput("t1IrHeld", 32'(ir), 32'h1263);

        memLat  = 0;
        memData = 16'h5020;
        applyStimulus(16'h3001, 1'b1, 16'h5020, 1'b0, 1);
        waitIdle(20);

        // No ack at all: fault after MAX_WAIT cycles, then cleared by the next request.
        memLat = -1;
        applyStimulus(16'h4000, 1'b1, 16'hF025, 1'b1, 15);
        waitCycles(14);
        checkOutput("t3RdHeld", 32'(memRd), 32'h1);
        checkOutput("t3AddrHeld", 32'(memAddr), 32'h4000);
        checkOutput("t3BusyHeld", 32'(busy), 32'h1);
        waitCycles(1);
        checkOutput("t3RdDropped", 32'(memRd), 32'h0);
        checkOutput("t3Busy", 32'(busy), 32'h0);
        checkOutput("t3Fault", 32'(fetchFault), 32'h1);
        memLat  = 0;
        memData = 16'h1111;
        applyStimulus(16'h5000, 1'b1, 16'h1111, 1'b0, 1);
        checkOutput("t3FaultCleared", 32'(fetchFault), 32'h0);
        waitIdle(20);

        // Ack arrives on the very edge the timeout would fire.
        memLat  = 14;
        memData = 16'h2222;
        applyStimulus(16'h5100, 1'b1, 16'h2222, 1'b0, 15);
        waitCycles(15);
        checkOutput("tEdgeFault", 32'(fetchFault), 32'h0);
        checkOutput("tEdgeRd", 32'(memRd), 32'h0);
        waitIdle(20);

        // Flush one cycle into WAIT; data discarded after draining.
        memLat  = 4;
        memData = 16'hABCD;
        applyStimulus(16'h6000, 1'b0, 16'h0000, 1'b0, 0);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("t4DrainBusy", 32'(busy), 32'h1);
        waitCycles(3);
        checkOutput("t4RdHeld", 32'(memRd), 32'h1);
        checkOutput("t4AddrHeld", 32'(memAddr), 32'h6000);
        waitCycles(1);
        checkOutput("t4BusyDone", 32'(busy), 32'h0);
        checkOutput("t4RdDone", 32'(memRd), 32'h0);
        checkOutput("t4IrKept", 32'(ir), 32'h2222);

        // Flush on the same edge as the ack.
        memLat  = 0;
        memData = 16'h7777;
        applyStimulus(16'h6100, 1'b0, 16'h0000, 1'b0, 0);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("t4bBusy", 32'(busy), 32'h0);
        checkOutput("t4bIrKept", 32'(ir), 32'h2222);

        // Asynchronous reset in the middle of a fetch, then a stray ack.
        memLat = -1;
        applyStimulus(16'h3100, 1'b0, 16'h0000, 1'b0, 0);
        waitCycles(2);
        checkOutput("t5BusyBefore", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("t5Ir", 32'(ir), 32'h0);
        checkOutput("t5IrValid", 32'(irValid), 32'h0);
        checkOutput("t5Busy", 32'(busy), 32'h0);
        checkOutput("t5Fault", 32'(fetchFault), 32'h0);
        checkOutput("t5MemRd", 32'(memRd), 32'h0);
        checkOutput("t5MemAddr", 32'(memAddr), 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        lateAck = 1'b1;
        waitCycles(1);
        lateAck = 1'b0;
        waitCycles(3);
        checkOutput("t5IrAfterLateAck", 32'(ir), 32'h0);
        checkOutput("t5RdAfterLateAck", 32'(memRd), 32'h0);
`endif

        waitCycles(4);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
